parking_gate_controller: RTL and testbench

PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

---
 rtl/parking_pkg.sv | 38 +++
 rtl/parking_gate_controller_gate_fsm.sv | 120 ++++++++++++
 rtl/parking_gate_controller.sv | 77 +++++++
 tb/tb_parking_gate_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared gate-state encoding, default timing constants and small helpers
// for the parking gate controller and its per-gate FSM.
package parking_pkg;

  localparam int SLOT_W = 5;
  localparam int TMO_W  = 8;
  localparam int DCNT_W = 4;

  localparam int DEF_MAXIMUM      = 5;
  localparam int DEF_MINIMUM      = 0;
  localparam int DEF_DEBOUNCE     = 4;
  localparam int DEF_OPEN_TIMEOUT = 20;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] OPEN    = 2'b01;
  localparam logic [1:0] PASSING = 2'b10;
  localparam logic [1:0] DONE    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_OPEN    = OPEN,
    ST_PASSING = PASSING,
    ST_DONE    = DONE
  } gate_state_e;

  function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
    if (v == {TMO_W{1'b1}}) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  function automatic logic gate_is_open(input gate_state_e s);
    return (s == ST_OPEN) || (s == ST_PASSING);
  endfunction

endpackage

// File: rtl/parking_gate_controller_gate_fsm.sv
// One barrier: debouncers for the request and pass sensors, the
// IDLE/OPEN/PASSING/DONE sequencer and the open-without-car timeout.
module gate_fsm
  import parking_pkg::*;
#(
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic req_raw,
  input  logic pass_raw,
  input  logic permit,
  output logic gate_open,
  output logic strobe
);

  localparam logic [DCNT_W-1:0] DB_LAST  = DCNT_W'(DEBOUNCE - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(OPEN_TIMEOUT - 1);

  logic [1:0]             raw_s;
  logic [1:0]             deb_q, deb_d;
  logic [1:0][DCNT_W-1:0] dcnt_q, dcnt_d;
  gate_state_e            state_q, state_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   open_q, open_d;
  logic                   strobe_q, strobe_d;
  logic                   req_deb_s, pass_deb_s;

  assign raw_s      = {pass_raw, req_raw};
  assign req_deb_s  = deb_q[0];
  assign pass_deb_s = deb_q[1];

  // Debounce: a differing raw value is accepted only after DEBOUNCE straight mismatches.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (raw_s[i] != deb_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          deb_d[i]  = raw_s[i];
          dcnt_d[i] = {DCNT_W{1'b0}};
        end else begin
          dcnt_d[i] = dcnt_q[i] + 4'd1;
        end
      end else begin
        dcnt_d[i] = {DCNT_W{1'b0}};
      end
    end
  end

  // Sequencer; permit is only consulted while idle so a slot change cannot abort a car.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        tmo_d = {TMO_W{1'b0}};
        if (req_deb_s && permit) begin
          state_d = ST_OPEN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (pass_deb_s) begin
          state_d = ST_PASSING;
          tmo_d   = {TMO_W{1'b0}};
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = {TMO_W{1'b0}};
        end else begin
          tmo_d = sat_inc_tmo(tmo_q);
        end
      end
      ST_PASSING: begin
        tmo_d = {TMO_W{1'b0}};
        if (!pass_deb_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_PASSING;
        end
      end
      ST_DONE: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are decoded from the next state so the flops track the state exactly.
    open_d   = gate_is_open(state_d);
    strobe_d = (state_d == ST_DONE);
  end

  // State, debounce and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q    <= 2'b00;
      dcnt_q   <= {2*DCNT_W{1'b0}};
      state_q  <= ST_IDLE;
      tmo_q    <= {TMO_W{1'b0}};
      open_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      deb_q    <= deb_d;
      dcnt_q   <= dcnt_d;
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      open_q   <= open_d;
      strobe_q <= strobe_d;
    end
  end

  assign gate_open = open_q;
  assign strobe    = strobe_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Parking lot entry/exit barrier controller: two independent gate
// sequencers plus the capacity permits and the registered full flag.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int MAXIMUM      = DEF_MAXIMUM,
  parameter int MINIMUM      = DEF_MINIMUM,
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              entry_req,
  input  logic              entry_pass,
  input  logic              exit_req,
  input  logic              exit_pass,
  input  logic [SLOT_W-1:0] slots,
  output logic              entry,
  output logic              exit,
  output logic              entry_open,
  output logic              exit_open,
  output logic              full
);

  localparam logic [SLOT_W-1:0] MAX_S = SLOT_W'(MAXIMUM);
  localparam logic [SLOT_W-1:0] MIN_S = SLOT_W'(MINIMUM);

  logic entry_permit_s;
  logic exit_permit_s;
  logic full_q, full_d;

  assign entry_permit_s = (slots > MIN_S);
  assign exit_permit_s  = (slots < MAX_S);

  // Full flag tracks slots with one cycle of latency.
  always_comb begin
    full_d = (slots == MIN_S);
  end

  // Full flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  assign full = full_q;

  gate_fsm #(
    .DEBOUNCE     (DEBOUNCE),
    .OPEN_TIMEOUT (OPEN_TIMEOUT)
  ) u_entry_gate (
    .clk       (clk),
    .reset     (reset),
    .req_raw   (entry_req),
    .pass_raw  (entry_pass),
    .permit    (entry_permit_s),
    .gate_open (entry_open),
    .strobe    (entry)
  );

  gate_fsm #(
    .DEBOUNCE     (DEBOUNCE),
    .OPEN_TIMEOUT (OPEN_TIMEOUT)
  ) u_exit_gate (
    .clk       (clk),
    .reset     (reset),
    .req_raw   (exit_req),
    .pass_raw  (exit_pass),
    .permit    (exit_permit_s),
    .gate_open (exit_open),
    .strobe    (exit)
  );

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed-vector bench for parking_gate_controller (DEBOUNCE=4,
// OPEN_TIMEOUT=20, MAXIMUM=5, MINIMUM=0); cycle counts are hand-derived.
module tb_parking_gate_controller;

  logic       clk;
  logic       reset;
  logic       entry_req, entry_pass, exit_req, exit_pass;
  logic [4:0] slots;
  logic       entry_strb, exit_strb, entry_open, exit_open, full;

  int n_tests = 0;
  int n_fail  = 0;
  int n_entry_strb = 0, n_exit_strb = 0, n_both = 0, n_eopen = 0, n_xopen = 0;
  int b_entry, b_exit, b_both, b_eopen, b_xopen;
  int slot_model;

  parking_gate_controller #(
    .MAXIMUM      (5),
    .MINIMUM      (0),
    .DEBOUNCE     (4),
    .OPEN_TIMEOUT (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (entry_req),
    .entry_pass (entry_pass),
    .exit_req   (exit_req),
    .exit_pass  (exit_pass),
    .slots      (slots),
    .entry      (entry_strb),
    .exit       (exit_strb),
    .entry_open (entry_open),
    .exit_open  (exit_open),
    .full       (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-cycle activity counters sampled mid-cycle.
  always @(negedge clk) begin
    if (entry_strb) n_entry_strb++;
    if (exit_strb) n_exit_strb++;
    if (entry_strb && exit_strb) n_both++;
    if (entry_open) n_eopen++;
    if (exit_open) n_xopen++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_entry = n_entry_strb;
    b_exit  = n_exit_strb;
    b_both  = n_both;
    b_eopen = n_eopen;
    b_xopen = n_xopen;
  endtask

  initial begin
    reset = 1'b1;
    entry_req = 1'b0; entry_pass = 1'b0; exit_req = 1'b0; exit_pass = 1'b0;
    slots = 5'd0;
    repeat (3) step();
    check("rst_entry_open", int'(entry_open), 0);
    check("rst_exit_open", int'(exit_open), 0);
    check("rst_entry", int'(entry_strb), 0);
    check("rst_exit", int'(exit_strb), 0);
    check("rst_full", int'(full), 0);
    reset = 1'b0;
    step();
    check("full_after_rst", int'(full), 1);

    // Lot full: request held for 100 cycles never opens.
    snap();
    entry_req = 1'b1;
    repeat (100) step();
    check("full_no_open", n_eopen - b_eopen, 0);
    check("full_no_strobe", n_entry_strb - b_entry, 0);
    check("full_flag", int'(full), 1);
    entry_req = 1'b0;
    repeat (6) step();

    // Full flag latency, then exit refused when the lot is empty.
    slots = 5'd5;
    check("full_latency_old", int'(full), 1);
    step();
    check("full_latency_new", int'(full), 0);
    snap();
    exit_req = 1'b1;
    repeat (30) step();
    check("empty_no_exit_open", n_xopen - b_xopen, 0);
    exit_req = 1'b0;
    repeat (6) step();

    // Normal entry: open at edge 5, strobe at edge 20 after pass falls at edge 15.
    snap();
    entry_req = 1'b1;
    repeat (4) step();
    check("ent_open_e4", int'(entry_open), 0);
    step();
    check("ent_open_e5", int'(entry_open), 1);
    entry_pass = 1'b1;
    repeat (10) step();
    check("ent_open_passing", int'(entry_open), 1);
    entry_pass = 1'b0;
    entry_req  = 1'b0;
    repeat (4) step();
    check("ent_open_e19", int'(entry_open), 1);
    check("ent_strb_e19", int'(entry_strb), 0);
    step();
    check("ent_strb_e20", int'(entry_strb), 1);
    check("ent_open_e20", int'(entry_open), 0);
    step();
    check("ent_strb_e21", int'(entry_strb), 0);
    repeat (5) step();
    check("ent_strb_count", n_entry_strb - b_entry, 1);
    check("ent_open_cycles", n_eopen - b_eopen, 15);

    // Three-cycle pass glitch while open: must time out, not pass.
    snap();
    entry_req = 1'b1;
    repeat (5) step();
    check("glitch_open", int'(entry_open), 1);
    entry_pass = 1'b1;
    repeat (3) step();
    entry_pass = 1'b0;
    entry_req  = 1'b0;
    repeat (16) step();
    check("glitch_open_e24", int'(entry_open), 1);
    step();
    check("glitch_closed_e25", int'(entry_open), 0);
    repeat (5) step();
    check("glitch_no_strobe", n_entry_strb - b_entry, 0);
    check("glitch_open_cycles", n_eopen - b_eopen, 20);

    // Exit timeout: open exactly 20 cycles, no strobe.
    slots = 5'd3;
    step();
    snap();
    exit_req = 1'b1;
    repeat (10) step();
    exit_req = 1'b0;
    repeat (14) step();
    check("tmo_open_e24", int'(exit_open), 1);
    step();
    check("tmo_closed_e25", int'(exit_open), 0);
    repeat (5) step();
    check("tmo_open_cycles", n_xopen - b_xopen, 20);
    check("tmo_no_strobe", n_exit_strb - b_exit, 0);

    // Coincident DONE on both gates.
    snap();
    entry_req = 1'b1;
    exit_req  = 1'b1;
    repeat (5) step();
    check("both_entry_open", int'(entry_open), 1);
    check("both_exit_open", int'(exit_open), 1);
    entry_pass = 1'b1;
    exit_pass  = 1'b1;
    repeat (10) step();
    entry_pass = 1'b0; exit_pass = 1'b0;
    entry_req  = 1'b0; exit_req  = 1'b0;
    repeat (5) step();
    check("both_entry_strb", int'(entry_strb), 1);
    check("both_exit_strb", int'(exit_strb), 1);
    repeat (6) step();
    check("both_same_cycle", n_both - b_both, 1);
    slot_model = 3 - (n_entry_strb - b_entry) + (n_exit_strb - b_exit);
    check("both_slots_same", slot_model, 3);

    // Reset while passing closes the gate at once, then the gate restarts cleanly.
    slots = 5'd5;
    step();
    snap();
    entry_req = 1'b1;
    repeat (5) step();
    entry_pass = 1'b1;
    repeat (35) step();
    check("passing_no_timeout", int'(entry_open), 1);
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_close", int'(entry_open), 0);
    check("rst_async_strobe", int'(entry_strb), 0);
    entry_req  = 1'b0;
    entry_pass = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("post_rst_closed", int'(entry_open), 0);
    entry_req = 1'b1;
    repeat (4) step();
    check("post_rst_e4", int'(entry_open), 0);
    step();
    check("post_rst_e5", int'(entry_open), 1);
    entry_req = 1'b0;
    repeat (25) step();
    check("post_rst_closed_end", int'(entry_open), 0);
    check("rst_no_strobe", n_entry_strb - b_entry, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
